mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous RAM between the core's instruction-fetch port and its

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter in front of a single-port 1-cycle-latency RAM, with starvation guard for fetch.
// Optional stall counters (perf_if_stall/perf_d_stall) are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_d_stall
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             d_we_q, d_we_d;
  logic             starved;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if (if_req && (starved || !d_req)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = d_gnt ? d_be : {BE_W{1'b0}};
    mem_wdata = d_gnt ? d_wdata : {DATA_W{1'b0}};
    if (d_gnt) begin
      mem_addr = d_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end else begin
      mem_addr = {ADDR_W{1'b0}};
    end
  end

  always_comb begin
    owner_d      = IDLE;
    d_we_d       = d_we_q;
    starve_cnt_d = {CNT_W{1'b0}};
    if (if_gnt) begin
      owner_d = RESP_IF;
    end else if (d_gnt) begin
      owner_d = RESP_D;
      d_we_d  = d_we;
    end
    if (if_req && !if_gnt) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= IDLE;
      starve_cnt_q <= {CNT_W{1'b0}};
      d_we_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      d_we_q       <= d_we_d;
    end
  end

  // Store acks return zero data; only loads forward the RAM word.
  always_comb begin
    if_rvalid = (owner_q == RESP_IF);
    d_rvalid  = (owner_q == RESP_D);
    if_rdata  = if_rvalid ? mem_rdata : {DATA_W{1'b0}};
    d_rdata   = (d_rvalid && !d_we_q) ? mem_rdata : {DATA_W{1'b0}};
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_q <= 32'd0;
      perf_d_q  <= 32'd0;
    end else begin
      if (if_req && !if_gnt) begin
        perf_if_q <= perf_if_q + 32'd1;
      end
      if (d_req && !d_gnt) begin
        perf_d_q <= perf_d_q + 32'd1;
      end
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_d_stall  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural RAM, directed scenarios and random traffic
// against a rule-level reference model. Perf counter checks are built when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall;
  logic [31:0] perf_d_stall;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (i * 32'h01010101) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural single-port RAM with one cycle of read latency.
  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = initWord(i);
    mem_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  int checks = 0;
  int fails  = 0;

  // Reference model state: fetch denial run, pending response and a shadow copy of memory.
  int          mStarve;
  int          mPend;
  logic [31:0] mPendData;
  logic [31:0] shadow [256];

  logic        lastIfGnt, lastDGnt, lastDRvalid;
  logic [31:0] lastIfRdata, lastDRdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [3:0] db, input logic [31:0] da,
                               input logic [31:0] dwd);
    logic expIf, expD;
    @(negedge clk);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dwd;
    #1;
    expIf = ir && ((mStarve == STARVE) || !dr);
    expD  = dr && !expIf;
    checkOutput("if_gnt", if_gnt, expIf);
    checkOutput("d_gnt", d_gnt, expD);
    checkOutput("mem_en", mem_en, expIf | expD);
    checkOutput("if_rvalid", if_rvalid, mPend == 1);
    checkOutput("if_rdata", if_rdata, (mPend == 1) ? mPendData : 32'd0);
    checkOutput("d_rvalid", d_rvalid, mPend == 2);
    checkOutput("d_rdata", d_rdata, (mPend == 2) ? mPendData : 32'd0);
    if (expIf) begin
      checkOutput("mem_addr_if", mem_addr, ia);
      checkOutput("mem_we_if", mem_we, 1'b0);
      checkOutput("mem_be_if", mem_be, 4'h0);
    end
    if (expD) begin
      checkOutput("mem_addr_d", mem_addr, da);
      checkOutput("mem_we_d", mem_we, dw);
      checkOutput("mem_be_d", mem_be, db);
      if (dw) checkOutput("mem_wdata", mem_wdata, dwd);
    end
    lastIfGnt = if_gnt; lastDGnt = d_gnt; lastDRvalid = d_rvalid;
    lastIfRdata = if_rdata; lastDRdata = d_rdata;
    if (ir && !expIf) mStarve = (mStarve < STARVE) ? mStarve + 1 : STARVE;
    else mStarve = 0;
    mPend = 0;
    mPendData = 32'd0;
    if (expIf) begin
      mPend = 1;
      mPendData = shadow[ia[9:2]];
    end else if (expD) begin
      mPend = 2;
      if (dw) begin
        for (int b = 0; b < 4; b++)
          if (db[b]) shadow[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
      end else begin
        mPendData = shadow[da[9:2]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int grantCycle;
    logic fetchPending;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perfIf0, perfD0;
`endif
    for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
    mStarve = 0; mPend = 0; mPendData = 32'd0;

    // Reset holds everything quiet even with both requests asserted.
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    d_addr = 32'h0; d_wdata = 32'h0;
    #3;
    checkOutput("rst_if_gnt", if_gnt, 1'b0);
    checkOutput("rst_d_gnt", d_gnt, 1'b0);
    checkOutput("rst_mem_en", mem_en, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_if_rvalid", if_rvalid, 1'b0);
    checkOutput("rst_d_rvalid", d_rvalid, 1'b0);
`ifdef MEM_ARB_PERF_EN
    checkOutput("rst_perf_if", perf_if_stall, 32'd0);
    checkOutput("rst_perf_d", perf_d_stall, 32'd0);
`endif
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    rst = 1'b1;

    $display("[TB] fetch-only stream");
    applyStimulus(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t1_gnt0", lastIfGnt, 1'b1);
    applyStimulus(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t1_rdata0", lastIfRdata, initWord(0));
    applyStimulus(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t1_rdata1", lastIfRdata, initWord(1));
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t1_rdata2", lastIfRdata, initWord(2));

    $display("[TB] collision");
    applyStimulus(1, 32'h200, 1, 0, 4'h0, 32'h100, 32'h0);
    checkOutput("t2_if_gnt", lastIfGnt, 1'b0);
    checkOutput("t2_d_gnt", lastDGnt, 1'b1);
    applyStimulus(1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t2_d_rvalid", lastDRvalid, 1'b1);
    checkOutput("t2_d_rdata", lastDRdata, initWord(32'h100 >> 2));
    checkOutput("t2_if_gnt_after", lastIfGnt, 1'b1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("[TB] starvation");
`ifdef MEM_ARB_PERF_EN
    perfIf0 = perf_if_stall;
    perfD0  = perf_d_stall;
`endif
    grantCycle = -1;
    fetchPending = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(fetchPending, 32'h300, 1, 0, 4'h0, 32'h104, 32'h0);
      if (lastIfGnt) begin
        grantCycle = i;
        fetchPending = 1'b0;
      end
    end
    checkOutput("t3_grant_cycle", grantCycle, 4);
`ifdef MEM_ARB_PERF_EN
    checkOutput("t6_perf_if", perf_if_stall - perfIf0, 32'd4);
    checkOutput("t6_perf_d", perf_d_stall - perfD0, 32'd1);
`endif
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("[TB] partial store");
    applyStimulus(0, 32'h0, 1, 1, 4'hF, 32'h20, 32'h11111111);
    applyStimulus(0, 32'h0, 1, 1, 4'b0011, 32'h20, 32'hAABBCCDD);
    checkOutput("t4_ack_data", lastDRdata, 32'd0);
    applyStimulus(0, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0);
    checkOutput("t4_ack_valid", lastDRvalid, 1'b1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t4_merge", lastDRdata, 32'h1111CCDD);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 32'h0, 1, 0, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b0;
    #1;
    checkOutput("t5_pre_rvalid", d_rvalid, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("t5_d_rvalid", d_rvalid, 1'b0);
    checkOutput("t5_mem_en", mem_en, 1'b0);
    checkOutput("t5_if_gnt", if_gnt, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b1;
    mStarve = 0; mPend = 0; mPendData = 32'd0;
    applyStimulus(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t5_post_gnt", lastIfGnt, 1'b1);
    applyStimulus(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("t5_post_rdata", lastIfRdata, initWord(0));

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
    end
    applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
